// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode, register file, writeback and execute signals of operand_fetch
interface operand_fetch_if #(
  parameter int CTRL_W = 16,
  parameter int PC_W   = 32
);
  // decode side
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        in_rj;
  logic [4:0]        in_rk;
  logic [4:0]        in_rd;
  logic              in_rd_we;
  // register file read ports (registered, one cycle latency)
  logic [4:0]        rf_raddr1;
  logic [4:0]        rf_raddr2;
  logic [31:0]       rf_rdata1;
  logic [31:0]       rf_rdata2;
  // writeback (same signals feed the register file)
  logic              wb_we;
  logic [4:0]        wb_waddr;
  logic [31:0]       wb_wdata;
  // execute side
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [31:0]       out_src1;
  logic [31:0]       out_src2;
  logic [4:0]        out_rd;
  logic              out_rd_we;

  // upstream/testbench view: drives decode, rf data, writeback and out_ready
  modport master (
    output in_valid, in_pc, in_ctrl, in_rj, in_rk, in_rd, in_rd_we,
    output rf_rdata1, rf_rdata2,
    output wb_we, wb_waddr, wb_wdata,
    output out_ready,
    input  in_ready, rf_raddr1, rf_raddr2,
    input  out_valid, out_pc, out_ctrl, out_src1, out_src2, out_rd, out_rd_we
  );

  // operand_fetch view
  modport slave (
    input  in_valid, in_pc, in_ctrl, in_rj, in_rk, in_rd, in_rd_we,
    input  rf_rdata1, rf_rdata2,
    input  wb_we, wb_waddr, wb_wdata,
    input  out_ready,
    output in_ready, rf_raddr1, rf_raddr2,
    output out_valid, out_pc, out_ctrl, out_src1, out_src2, out_rd, out_rd_we
  );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage with writeback bypass and scoreboard; optional counters under OPERAND_FETCH_STALL_CNT_EN
module operand_fetch #(
  parameter int CTRL_W = 16,
  parameter int PC_W   = 32
) (
  input  logic clk,
  input  logic reset,
  operand_fetch_if.slave bus
`ifdef OPERAND_FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] issue_cnt
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       pending_q, pending_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [4:0]        rd_q, rd_d;
  logic              rd_we_q, rd_we_d;
  logic [4:0]        rj_q, rj_d;
  logic [4:0]        rk_q, rk_d;
  logic              byp_we_q, byp_we_d;
  logic [4:0]        byp_addr_q, byp_addr_d;
  logic [31:0]       byp_data_q, byp_data_d;
  logic [31:0]       hold_src1_q, hold_src1_d;
  logic [31:0]       hold_src2_q, hold_src2_d;

  logic              out_valid;
  logic              out_fire;
  logic [31:0]       wb_clr;
  logic [31:0]       pending_eff;
  logic              hazard;
  logic              in_ready;
  logic              accept;
  logic [31:0]       read_src1;
  logic [31:0]       read_src2;

  // Register-file data is from before the write on the same edge, so a
  // write registered alongside the read must override it; r0 reads as zero.
  function automatic logic [31:0] pick_src(
    input logic [4:0]  src,
    input logic [31:0] rdata,
    input logic        byp_we,
    input logic [4:0]  byp_addr,
    input logic [31:0] byp_data
  );
    logic [31:0] val;
    if (src == 5'd0) begin
      val = 32'd0;
    end else if (byp_we && (byp_addr == src)) begin
      val = byp_data;
    end else begin
      val = rdata;
    end
    return val;
  endfunction

  // Hazard detection: a pending bit being retired by this cycle's writeback no longer blocks
  always_comb begin
    wb_clr = 32'd0;
    if (bus.wb_we) begin
      wb_clr[bus.wb_waddr] = 1'b1;
    end
    pending_eff = pending_q & ~wb_clr;
    hazard = 1'b0;
    if ((bus.in_rj != 5'd0) && pending_eff[bus.in_rj]) begin
      hazard = 1'b1;
    end
    if ((bus.in_rk != 5'd0) && pending_eff[bus.in_rk]) begin
      hazard = 1'b1;
    end
    if (bus.in_rd_we && (bus.in_rd != 5'd0) && pending_eff[bus.in_rd]) begin
      hazard = 1'b1;
    end
  end

  // Handshake and read-address generation
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    out_fire  = out_valid && bus.out_ready;
    in_ready  = ((state_q == S_EMPTY) || out_fire) && !hazard;
    accept    = bus.in_valid && in_ready;
    read_src1 = pick_src(rj_q, bus.rf_rdata1, byp_we_q, byp_addr_q, byp_data_q);
    read_src2 = pick_src(rk_q, bus.rf_rdata2, byp_we_q, byp_addr_q, byp_data_q);
  end

  assign bus.in_ready  = in_ready;
  assign bus.rf_raddr1 = accept ? bus.in_rj : 5'd0;
  assign bus.rf_raddr2 = accept ? bus.in_rk : 5'd0;

  assign bus.out_valid = out_valid;
  assign bus.out_pc    = pc_q;
  assign bus.out_ctrl  = ctrl_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_rd_we = rd_we_q;
  assign bus.out_src1  = (state_q == S_READ) ? read_src1 : hold_src1_q;
  assign bus.out_src2  = (state_q == S_READ) ? read_src2 : hold_src2_q;

  // Next-state: FSM, instruction capture, bypass registers, hold registers, scoreboard
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    rj_d        = rj_q;
    rk_d        = rk_q;
    hold_src1_d = hold_src1_q;
    hold_src2_d = hold_src2_q;

    // writeback is sampled every cycle so it lines up with the rf read data
    byp_we_d    = bus.wb_we;
    byp_addr_d  = bus.wb_waddr;
    byp_data_d  = bus.wb_wdata;

    if (accept) begin
      pc_d    = bus.in_pc;
      ctrl_d  = bus.in_ctrl;
      rd_d    = bus.in_rd;
      rd_we_d = bus.in_rd_we;
      rj_d    = bus.in_rj;
      rk_d    = bus.in_rk;
    end

    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (bus.out_ready) begin
          state_d = accept ? S_READ : S_EMPTY;
        end else begin
          // rf data is only valid this one cycle; park it
          hold_src1_d = read_src1;
          hold_src2_d = read_src2;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = accept ? S_READ : S_EMPTY;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    // clear first so a same-cycle set on the same bit wins
    pending_d = pending_q & ~wb_clr;
    if (accept && bus.in_rd_we && (bus.in_rd != 5'd0)) begin
      pending_d[bus.in_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      pending_q   <= 32'd0;
      pc_q        <= '0;
      ctrl_q      <= '0;
      rd_q        <= 5'd0;
      rd_we_q     <= 1'b0;
      rj_q        <= 5'd0;
      rk_q        <= 5'd0;
      byp_we_q    <= 1'b0;
      byp_addr_q  <= 5'd0;
      byp_data_q  <= 32'd0;
      hold_src1_q <= 32'd0;
      hold_src2_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pc_q        <= pc_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      rj_q        <= rj_d;
      rk_q        <= rk_d;
      byp_we_q    <= byp_we_d;
      byp_addr_q  <= byp_addr_d;
      byp_data_q  <= byp_data_d;
      hold_src1_q <= hold_src1_d;
      hold_src2_q <= hold_src2_d;
    end
  end

`ifdef OPERAND_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] issue_cnt_q, issue_cnt_d;

  // Free-running wrap-around counters of stalled and issued cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    issue_cnt_d = issue_cnt_q;
    if (bus.in_valid && hazard) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (out_fire) begin
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      issue_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign issue_cnt = issue_cnt_q;
`endif

endmodule
